// File: rtl/mdu.sv
// Multiply/divide unit holding the architectural HI/LO pair.
// Results are computed when an op is accepted and committed when the busy count expires.
module mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] MDUOut,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } op_e;

    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] tmp_hi_q, tmp_hi_d, tmp_lo_q, tmp_lo_d;
    logic        commit_q, commit_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;

    logic        accept;
    logic        div_zero, div_ovf;
    logic [31:0] divisor;
    logic signed [63:0] prod_s;
    logic [63:0] prod_u;
    logic signed [31:0] quo_s, rem_s;
    logic [31:0] quo_u, rem_u;

    // Divisor is forced to 1 on divide-by-zero so the dividers never see 0;
    // the result is discarded via commit_q anyway.
    always_comb begin
        div_zero = (B == '0);
        div_ovf  = (A == 32'h8000_0000) && (B == '1);
        divisor  = div_zero ? 32'd1 : B;
        prod_s   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u   = {32'd0, A} * {32'd0, B};
        quo_u    = A / divisor;
        rem_u    = A % divisor;
        if (div_ovf) begin
            quo_s = $signed(A);
            rem_s = '0;
        end else begin
            quo_s = $signed(A) / $signed(divisor);
            rem_s = $signed(A) % $signed(divisor);
        end
    end

    always_comb begin
        hi_d     = hi_q;
        lo_d     = lo_q;
        tmp_hi_d = tmp_hi_q;
        tmp_lo_d = tmp_lo_q;
        commit_d = commit_q;
        cnt_d    = (cnt_q != '0) ? cnt_q - 4'd1 : cnt_q;
        accept   = Start && !busy_q && (MDUOp != OP_NONE) && (MDUOp <= OP_MTLO);

        if ((cnt_q == 4'd1) && commit_q) begin
            hi_d = tmp_hi_q;
            lo_d = tmp_lo_q;
        end

        if (accept) begin
            case (MDUOp)
                OP_MULT: begin
                    tmp_hi_d = prod_s[63:32];
                    tmp_lo_d = prod_s[31:0];
                    commit_d = 1'b1;
                    cnt_d    = 4'(MULT_CYCLES);
                end
                OP_MULTU: begin
                    tmp_hi_d = prod_u[63:32];
                    tmp_lo_d = prod_u[31:0];
                    commit_d = 1'b1;
                    cnt_d    = 4'(MULT_CYCLES);
                end
                OP_DIV: begin
                    tmp_hi_d = rem_s;
                    tmp_lo_d = quo_s;
                    commit_d = !div_zero;
                    cnt_d    = 4'(DIV_CYCLES);
                end
                OP_DIVU: begin
                    tmp_hi_d = rem_u;
                    tmp_lo_d = quo_u;
                    commit_d = !div_zero;
                    cnt_d    = 4'(DIV_CYCLES);
                end
                OP_MTHI: hi_d = A;
                OP_MTLO: lo_d = A;
                default: ;
            endcase
        end

        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q     <= '0;
            lo_q     <= '0;
            tmp_hi_q <= '0;
            tmp_lo_q <= '0;
            commit_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            tmp_hi_q <= tmp_hi_d;
            tmp_lo_q <= tmp_lo_d;
            commit_q <= commit_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        case (MDUOp)
            OP_MFHI: MDUOut = hi_q;
            OP_MFLO: MDUOut = lo_q;
            default: MDUOut = '0;
        endcase
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: expected HI/LO/latency are queued at issue and
// checked when Busy drops.
module tb_mdu;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [3:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] MDUOut;
    logic [31:0] HI;
    logic [31:0] LO;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .Start  (Start),
        .MDUOp  (MDUOp),
        .A      (A),
        .B      (B),
        .Busy   (Busy),
        .MDUOut (MDUOut),
        .HI     (HI),
        .LO     (LO)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          passed = 0;
    int          total  = 0;
    logic [31:0] mhi    = '0;
    logic [31:0] mlo    = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Entered at a negedge; leaves at the negedge just after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input int ecyc);
        exp_t e;
        e.hi = ehi; e.lo = elo; e.cyc = ecyc;
        sb.push_back(e);
        Start = 1'b1; MDUOp = op; A = a; B = b;
        @(negedge clk);
        Start = 1'b0; MDUOp = 4'd0;
    endtask

    // Counts Busy cycles, checks HI/LO/mflo hold the old values meanwhile,
    // optionally presents an mtlo 0x55 at Busy cycle `inject`.
    task automatic wait_done(input string tag, input int inject);
        exp_t e;
        int   cyc = 0;
        while (Busy === 1'b1 && cyc < 40) begin
            cyc++;
            if (cyc == inject) begin
                Start = 1'b1; MDUOp = 4'd8; A = 32'h55;
            end else begin
                Start = 1'b0; MDUOp = 4'd6;
                #1;
                chk({tag, "_mflo_busy"}, MDUOut, mlo);
            end
            chk({tag, "_hi_hold"}, HI, mhi);
            chk({tag, "_lo_hold"}, LO, mlo);
            @(negedge clk);
        end
        Start = 1'b0; MDUOp = 4'd0;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_busy_cycles"}, 32'(cyc), 32'(e.cyc));
            chk({tag, "_hi"}, HI, e.hi);
            chk({tag, "_lo"}, LO, e.lo);
            mhi = e.hi;
            mlo = e.lo;
        end
    endtask

    initial begin
        reset = 1'b1; Start = 1'b0; MDUOp = 4'd0; A = '0; B = '0;
        #3;
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        issue(4'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        wait_done("mult_neg2x3", 0);
        Start = 1'b1; MDUOp = 4'd5; #1;
        chk("mfhi", MDUOut, 32'hFFFF_FFFF);
        @(negedge clk);
        MDUOp = 4'd6; #1;
        chk("mflo", MDUOut, 32'hFFFF_FFFA);
        @(negedge clk);
        Start = 1'b0; MDUOp = 4'd0; #1;
        chk("mduout_none", MDUOut, 32'd0);
        chk("mfx_hi_nochange", HI, mhi);
        chk("mfx_lo_nochange", LO, mlo);
        chk("mfx_busy", {31'd0, Busy}, 32'd0);
        @(negedge clk);

        issue(4'd2, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 5);
        wait_done("multu", 0);

        issue(4'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        wait_done("div_m7_2", 0);

        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10);
        wait_done("div_ovf", 0);

        Start = 1'b1; MDUOp = 4'd7; A = 32'h11;
        @(negedge clk);
        MDUOp = 4'd8; A = 32'h22;
        @(negedge clk);
        Start = 1'b0; MDUOp = 4'd0;
        chk("mthi", HI, 32'h11);
        chk("mtlo", LO, 32'h22);
        chk("mtx_busy", {31'd0, Busy}, 32'd0);
        mhi = 32'h11; mlo = 32'h22;

        Start = 1'b1; MDUOp = 4'd9; A = 32'hDEAD_BEEF; B = 32'd1;
        @(negedge clk);
        Start = 1'b0; MDUOp = 4'd0;
        chk("op9_hi", HI, mhi);
        chk("op9_lo", LO, mlo);
        chk("op9_busy", {31'd0, Busy}, 32'd0);

        issue(4'd4, 32'd1234, 32'd0, 32'h11, 32'h22, 10);
        wait_done("divu_by0", 0);

        issue(4'd1, 32'd2, 32'd3, 32'd0, 32'd6, 5);
        wait_done("mult_ignore_mtlo", 2);

        issue(4'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy_before", {31'd0, Busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        chk("abort_hi", HI, 32'd0);
        chk("abort_lo", LO, 32'd0);
        #1 reset = 1'b0;
        void'(sb.pop_front());
        mhi = '0; mlo = '0;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            chk("post_abort_busy", {31'd0, Busy}, 32'd0);
            chk("post_abort_hi", HI, 32'd0);
            chk("post_abort_lo", LO, 32'd0);
            @(negedge clk);
        end

        issue(4'd1, 32'd7, 32'd6, 32'd0, 32'd42, 5);
        wait_done("mult_after_reset", 0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
